tft_textmem_ctrl: RTL
=====================

Name: tft_textmem_ctrl

Overview:
- Owns write port B of the TFT text-mode memory (32-bit words, byte-addressed, 1-cycle synchronous read latency).
- Arbitrates that port between the CPU bus and an internal bulk engine that executes CLEAR-screen and SCROLL-UP-one-line commands.
- Display scan-out uses read-only port A and is not affected by this block.
- Text layout is COLS_WORDS words per character row (4 chars/word) by ROWS rows, starting at byte address 0.

Parameters:
- MEM_SIZE, 8192: text memory size in bytes; ADDR_W = $clog2(MEM_SIZE).
- COLS_WORDS, 25: words per character row (100 columns).
- ROWS, 30: character rows.
- FILL_BYTE, 8'h20: byte written by CLEAR and into the scrolled-in bottom row.
- STARVE_LIMIT, 8: consecutive stalled engine cycles before the engine forces one cycle of port ownership.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address; low 2 bits ignored
- cpu_wdata  in  32  write data
- cpu_be  in  4  byte enables
- cpu_ready  out  1  combinational grant; access completes in this cycle
- cpu_rdata  out  32  read data
- cpu_rvalid  out  1  read data valid
- cmd_valid  in  1  command request
- cmd_op  in  2  00 = CLEAR, 01 = SCROLL, 1x = reserved
- cmd_ready  out  1  command may be accepted
- busy  out  1  engine active
- done  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  port B byte address
- mem_wdata  out  32  port B write data
- mem_be  out  4  port B byte enables
- mem_we  out  1  port B write enable
- mem_rdata  in  32  port B read data, valid the cycle after the read

Behaviour:
- Reset is asynchronous, active-high; clock is clk. All state registers clear on reset: FSM goes to IDLE, counters and the stall counter go to 0. Outputs during reset: busy=0, done=0, cpu_rvalid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
- Reset mid-command aborts the command. Memory is left partially modified.
- Arbitration:
  - The CPU has priority: cpu_ready = cpu_req & ~force.
  - force is asserted when the stall counter equals STARVE_LIMIT and the engine needs the port.
  - The stall counter increments on each cycle the engine needs the port but the CPU is granted, and clears on each engine-owned cycle.
  - The engine uses the port only in cycles where cpu_ready=0.
- CPU access:
  - A granted CPU read drives mem_addr=cpu_addr with mem_we=0. Next cycle: cpu_rvalid=1 and cpu_rdata=mem_rdata.
  - A granted CPU write drives mem_we=1, mem_be=cpu_be, mem_wdata=cpu_wdata.
- Commands:
  - cmd_ready = (state==IDLE). A command is accepted when cmd_valid & cmd_ready.
  - busy=1 from the cycle after accept until the last engine write cycle, inclusive.
  - done pulses in the cycle after the last engine write, with busy=0 in that cycle.
  - A reserved op is accepted with no memory access; done pulses in the cycle after accept.
- FSM states: IDLE, CLR_WR, SCR_RD, SCR_WR, SCR_FILL, DONE.
- CLR_WR:
  - Word index i runs 0..N-1, with N = ROWS*COLS_WORDS.
  - Writes {4{FILL_BYTE}} to byte address i<<2 with be=4'hF.
  - i advances only on engine-owned cycles.
- SCR_RD / SCR_WR:
  - Word index i runs 0..M-1, with M = (ROWS-1)*COLS_WORDS.
  - SCR_RD issues a read of word i+COLS_WORDS, waiting while stalled.
  - The next cycle is always SCR_WR.
  - In the first SCR_WR cycle the write data is mem_rdata. That value is also latched into a hold register, and the hold register is used in later SCR_WR cycles if the write is stalled.
  - The write goes to word i.
  - After the write: i+1 returns to SCR_RD; after i = M-1, go to SCR_FILL.
- SCR_FILL: writes the fill word to words M..N-1.
- Unstalled cycle counts: CLEAR = N write cycles; SCROLL = 2M + COLS_WORDS cycles (1475 at defaults).
- Counter widths are sized for N. The last index transitions exactly; there is no wrap past N-1.
- An engine read and a CPU read never occur in the same cycle, so cpu_rvalid is raised only for CPU reads.

Test Plan:
- CLEAR at defaults, no CPU traffic:
  - Words 0..749 each get 32'h20202020, one write per cycle.
  - busy is high for exactly 750 cycles; done pulses at cycle 751; cmd_ready returns.
- SCROLL with memory preloaded word[k]=k, no CPU traffic:
  - Afterwards word[k]=k+25 for k<725, and words 725..749 = 32'h20202020.
  - Total engine cycles = 1475.
- CPU write then read of address 0x10 (wdata 32'hDEADBEEF, be=4'b0011) during SCROLL:
  - cpu_ready is immediate and the engine stalls without corrupting data.
  - The read returns the merged bytes with cpu_rvalid exactly 1 cycle after the grant.
- CPU stall between SCR_RD and SCR_WR for 3 cycles:
  - The held word is written correctly and no scrolled word is lost.
- Continuous cpu_req during CLEAR:
  - After 8 stalled cycles cpu_ready drops for one cycle and the engine writes one word.
  - This pattern repeats, and CLEAR still completes.
- Reset asserted mid-SCROLL at i=100:
  - All outputs go to 0 immediately and the FSM is in IDLE.
  - A new CLEAR command is then accepted normally.

Source files
------------

// File: rtl/tft_textmem_ctrl.sv
// Text-memory port B controller: arbitrates the port between CPU accesses and
// a bulk engine that clears the screen or scrolls it up by one character row.
module tft_textmem_ctrl #(
    parameter int unsigned MEM_SIZE     = 8192,
    parameter int unsigned COLS_WORDS   = 25,
    parameter int unsigned ROWS         = 30,
    parameter logic [7:0]  FILL_BYTE    = 8'h20,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned ADDR_W      = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned N       = ROWS * COLS_WORDS;
    localparam int unsigned M       = (ROWS - 1) * COLS_WORDS;
    localparam int unsigned IDX_W   = $clog2(N);
    localparam int unsigned STALL_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [IDX_W-1:0]   IDX_LAST_N = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST_M = IDX_W'(M - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STARVE_LIMIT);
    localparam logic [31:0]        FILL_WORD  = {4{FILL_BYTE}};

    typedef enum logic [2:0] {
        IDLE, CLR_WR, SCR_RD, SCR_WR, SCR_FILL, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        hold_q, hold_d;
    logic               first_q, first_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               rvalid_q;

    logic eng_need;
    logic force_own;
    logic eng_own;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] w);
        return ADDR_W'({w, 2'b00});
    endfunction

    // CPU has priority unless the engine has been starved long enough
    always_comb begin
        eng_need  = (state_q == CLR_WR) || (state_q == SCR_RD) ||
                    (state_q == SCR_WR) || (state_q == SCR_FILL);
        force_own = eng_need && (stall_q == STALL_MAX);
        cpu_ready = cpu_req && !force_own && !reset;
        eng_own   = eng_need && !cpu_ready;
    end

    // Port B mux: granted CPU access, else the engine's access for this state
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        mem_we    = 1'b0;
        if (cpu_ready) begin
            mem_addr = cpu_addr;
            mem_we   = cpu_we;
            if (cpu_we) begin
                mem_wdata = cpu_wdata;
                mem_be    = cpu_be;
            end
        end else if (eng_own) begin
            case (state_q)
                CLR_WR, SCR_FILL: begin
                    mem_addr  = word_addr(idx_q);
                    mem_wdata = FILL_WORD;
                    mem_be    = 4'hF;
                    mem_we    = 1'b1;
                end
                SCR_RD: begin
                    mem_addr = word_addr(idx_q + IDX_W'(COLS_WORDS));
                end
                SCR_WR: begin
                    mem_addr  = word_addr(idx_q);
                    mem_wdata = first_q ? mem_rdata : hold_q;
                    mem_be    = 4'hF;
                    mem_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state, word index, read-hold and starvation counter
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        first_d = first_q;
        stall_d = stall_q;

        if (eng_need && cpu_ready) begin
            stall_d = stall_q + STALL_W'(1);
        end else if (eng_own) begin
            stall_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    idx_d = '0;
                    case (cmd_op)
                        2'b00:   state_d = CLR_WR;
                        2'b01:   state_d = SCR_RD;
                        default: state_d = DONE;
                    endcase
                end
            end
            CLR_WR, SCR_FILL: begin
                if (eng_own) begin
                    if (idx_q == IDX_LAST_N) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SCR_RD: begin
                if (eng_own) begin
                    state_d = SCR_WR;
                    first_d = 1'b1;
                end
            end
            SCR_WR: begin
                // read data is only on mem_rdata in the first cycle; keep a copy
                first_d = 1'b0;
                if (first_q) begin
                    hold_d = mem_rdata;
                end
                if (eng_own) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = (idx_q == IDX_LAST_M) ? SCR_FILL : SCR_RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            first_q  <= 1'b0;
            stall_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            first_q  <= first_d;
            stall_q  <= stall_d;
            rvalid_q <= cpu_ready && !cpu_we;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = eng_need;
    assign done       = (state_q == DONE);
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rvalid_q ? mem_rdata : 32'h0;

endmodule
